// File: rtl/bus_memory_responder.sv
// rtl/bus_memory_responder.sv - memory-side responder for the CPU external bus
//
// Purpose: latches an address on ALE, serves reads from an internal RAM by driving
// the shared tri-state Data_Bus, and captures writes from Data_Bus. A side-band
// preload port writes the RAM in any state.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   Address_Bus  address from CPU, latched when ALE=1
//   Data_Bus     shared data bus; driven only while serving a read
//   Rw           1 = read, 0 = write; sampled when an access is accepted
//   En           access strobe, held high for the whole access
//   ALE          address latch enable, one-cycle pulse
//   Ready        read data valid / write committed
//   load_en      preload write strobe
//   load_addr    preload address
//   load_data    preload data
module bus_memory_responder #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Address_Bus,
  inout  wire  [DATA_W-1:0] Data_Bus,
  input  logic              Rw,
  input  logic              En,
  input  logic              ALE,
  output logic              Ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READ_WAIT,
    READ_DRIVE,
    WRITE_DONE
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              drive_q;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // An access is accepted from IDLE or ADDR when En is high and no new address
  // is being latched; IDLE without ALE reuses whatever addr_q already holds.
  logic accept;
  logic bus_wr;
  assign accept = ((state_q == IDLE) || (state_q == ADDR)) && !ALE && En;
  // A single RAM write port: a preload in the same cycle takes it and the bus
  // write of that access is lost.
  assign bus_wr = accept && !Rw && !load_en;

  // RAM is deliberately outside the reset domain so reset never clears it.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (bus_wr) begin
      mem[addr_q] <= Data_Bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      drive_q <= 1'b0;
      Ready   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ADDR: begin
          if (ALE) begin
            addr_q  <= Address_Bus;
            state_q <= ADDR;
          end else if (En) begin
            if (Rw) begin
              if (READ_LATENCY <= 1) begin
                rdata_q <= mem[addr_q];
                drive_q <= 1'b1;
                Ready   <= 1'b1;
                state_q <= READ_DRIVE;
              end else begin
                cnt_q   <= CNT_INIT;
                state_q <= READ_WAIT;
              end
            end else begin
              Ready   <= 1'b1;
              state_q <= WRITE_DONE;
            end
          end
        end
        READ_WAIT: begin
          if (ALE) begin
            addr_q  <= Address_Bus;
            state_q <= ADDR;
          end else if (!En) begin
            state_q <= IDLE;
          end else if (cnt_q <= 3'd1) begin
            // Last wait cycle: register the word so it appears on entry.
            cnt_q   <= '0;
            rdata_q <= mem[addr_q];
            drive_q <= 1'b1;
            Ready   <= 1'b1;
            state_q <= READ_DRIVE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        READ_DRIVE, WRITE_DONE: begin
          if (ALE) begin
            addr_q  <= Address_Bus;
            drive_q <= 1'b0;
            Ready   <= 1'b0;
            state_q <= ADDR;
          end else if (!En) begin
            drive_q <= 1'b0;
            Ready   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          drive_q <= 1'b0;
          Ready   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Live Rw and rst gate the driver so a CPU write cycle or a reset never sees
  // contention, even before the FSM has reacted.
  assign Data_Bus = (rst && drive_q && Rw) ? rdata_q : {DATA_W{1'bz}};

endmodule
